mcb_dat_ctrl: RTL and testbench
===============================

MCB_DAT_CTRL -- requirements
Module: mcb_dat_ctrl

Interface
REQ-001 The block SHALL have parameter pCL, default 3, meaning SDRAM CAS latency in cycles (legal 2..3).
REQ-002 The block SHALL have parameter pBL, default 4, meaning SDRAM burst length in beats (legal 1, 2, 4, 8).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The block SHALL have port mcb_clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-005 The block SHALL have port mcb_rst, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port mcb_sclr_n, input, 1 bit: synchronous active-low clear.
REQ-007 The block SHALL have port c_bst_num, input, 2 bits: burst count minus one; beats N = pBL*(c_bst_num+1).
REQ-008 The block SHALL have ports c_rd and c_rda, inputs, 1 bit each: a read (c_rda: with auto-precharge) is issued this cycle.
REQ-009 The block SHALL have ports c_wr and c_wra, inputs, 1 bit each: a write (c_wra: with auto-precharge) is issued this cycle.
REQ-010 The block SHALL have port c_wdat_req, input, 1 bit: write data is requested, one cycle before c_wr/c_wra.
REQ-011 The block SHALL have port mcb_rdat_vld, output, 1 bit: read data valid to the user, one per beat.
REQ-012 The block SHALL have port mcb_wdat_req, output, 1 bit: write data request to the user, one per beat.
REQ-013 The block SHALL have ports d_dp_ie, d_dp_oe and d_wr_ld, outputs, 1 bit each: datapath DQ capture enable, DQ output enable and write-register load.

Function
REQ-014 c_rd and c_rda SHALL behave identically here, as SHALL c_wr and c_wra; auto-precharge does not affect this block.
REQ-015 N SHALL be latched from c_bst_num in the cycle a read command or c_wdat_req is sampled.
REQ-016 Read sampled at edge R: d_dp_ie SHALL be high for exactly N consecutive cycles, starting on edge R+pCL+1.
REQ-017 mcb_rdat_vld SHALL be d_dp_ie delayed by exactly one cycle: N cycles, starting on edge R+pCL+2.
REQ-018 c_wdat_req sampled at edge T: mcb_wdat_req and d_wr_ld SHALL both be high for exactly N cycles, starting on edge T+1.
REQ-019 Write sampled at edge W (W=T+1): d_dp_oe SHALL be high for exactly N cycles, starting on edge W+1.
REQ-020 A read/CL pipeline and a write path SHALL run independently; a write may be requested while read data is still in flight.
REQ-021 A new command of the same type before the previous burst ends SHALL restart that path with the new N.
REQ-022 Read and c_wdat_req sampled in the same cycle SHALL both be accepted.
REQ-023 All outputs SHALL be registered, with no combinational path from input to output.
REQ-024 mcb_sclr_n low at an edge SHALL clear all state and outputs to 0 at that edge, overriding commands in the same cycle.

Reset
REQ-025 mcb_rst high SHALL immediately force all outputs, counters and pipeline stages to 0, with no clock needed.
REQ-026 A reset mid-burst SHALL abort the burst, with no resumption after release.
REQ-027 The first command after reset release SHALL be accepted on the next edge.

Structure
REQ-028 pCL, pBL and timing constants (tCK) SHALL reside in the shared MCB parameter package.
REQ-029 The burst beat counter SHALL be one sub-module, mcb_bst_cnt (load N, count down, busy flag), instantiated once for read and once for write.

Verification
REQ-030 Scenario: pCL=3, pBL=4, c_bst_num=0, c_rda at edge 3 -> d_dp_ie high on edges 7-10, mcb_rdat_vld high on edges 8-11.
REQ-031 Scenario: c_bst_num=1, c_rd pulse -> d_dp_ie high for 8 cycles after CL, mcb_rdat_vld the same 8 cycles shifted by one.
REQ-032 Scenario: c_bst_num=0, c_wdat_req at T, c_wra at T+1 -> mcb_wdat_req and d_wr_ld high on T+1..T+4, d_dp_oe high on T+2..T+5.
REQ-033 Scenario: c_bst_num=1 write sequence -> 8-cycle mcb_wdat_req/d_wr_ld window, 8-cycle d_dp_oe window.
REQ-034 Scenario: mcb_rst pulse mid read burst -> all outputs 0 immediately and no further beats.
REQ-035 Scenario: mcb_sclr_n low at an edge during a write burst -> all outputs 0 at that edge.

Source files
------------

// File: rtl/mcb_dat_ctrl_pkg.sv
// Shared MCB parameters: SDRAM CAS latency, burst length, clock period and
// the beat-count type used by the data-path burst counters.
package mcb_dat_ctrl_pkg;
    localparam int MCB_CL     = 3;
    localparam int MCB_BL     = 4;
    localparam int MCB_TCK_PS = 7500;
    // Largest burst is 8 beats * 4 bursts = 32, so 6 bits hold N.
    localparam int MCB_CNT_W  = 6;

    typedef logic [MCB_CNT_W-1:0] beat_cnt_t;

    function automatic beat_cnt_t beats(input int bl, input logic [1:0] bst_num);
        return beat_cnt_t'(bl * (int'(bst_num) + 1));
    endfunction
endpackage

// File: rtl/mcb_dat_ctrl_if.sv
// Command inputs from the MCB sequencer and data-path strobes to the user/PHY.
interface mcb_dat_ctrl_if;
    logic [1:0] c_bst_num;
    logic       c_rd;
    logic       c_rda;
    logic       c_wr;
    logic       c_wra;
    logic       c_wdat_req;
    logic       mcb_rdat_vld;
    logic       mcb_wdat_req;
    logic       d_dp_ie;
    logic       d_dp_oe;
    logic       d_wr_ld;

    modport master (
        output c_bst_num, c_rd, c_rda, c_wr, c_wra, c_wdat_req,
        input  mcb_rdat_vld, mcb_wdat_req, d_dp_ie, d_dp_oe, d_wr_ld
    );
    modport slave (
        input  c_bst_num, c_rd, c_rda, c_wr, c_wra, c_wdat_req,
        output mcb_rdat_vld, mcb_wdat_req, d_dp_ie, d_dp_oe, d_wr_ld
    );
endinterface

// File: rtl/mcb_bst_cnt.sv
// Burst beat counter: load N, count down, busy high for exactly N cycles.
// A load while busy restarts the burst with the new N.
module mcb_bst_cnt
    import mcb_dat_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      sclr_n,
    input  logic      load,
    input  beat_cnt_t n,
    output logic      busy
);
    beat_cnt_t cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (!sclr_n) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (load) begin
            cnt  <= n - beat_cnt_t'(1);
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == '0)
                busy <= 1'b0;
            else
                cnt <= cnt - beat_cnt_t'(1);
        end
    end
endmodule

// File: rtl/mcb_dat_ctrl.sv
// SDRAM data-path control: CAS-latency read pipeline and write data path,
// each timing its burst window with its own mcb_bst_cnt.
module mcb_dat_ctrl
    import mcb_dat_ctrl_pkg::*;
#(
    parameter int pCL = MCB_CL,
    parameter int pBL = MCB_BL
) (
    input  logic           mcb_clk,
    input  logic           mcb_rst,
    input  logic           mcb_sclr_n,
    mcb_dat_ctrl_if.slave  bus
);
    logic rd_cmd, wr_cmd;
    assign rd_cmd = bus.c_rd | bus.c_rda;
    assign wr_cmd = bus.c_wr | bus.c_wra;

    // Read command and its burst count travel together so a restart inside
    // the CL window still picks up the right N.
    logic [pCL:0]      rd_pipe;
    logic [pCL:0][1:0] bn_pipe;
    logic              wreq_q;
    logic [1:0]        wr_bn;
    logic              wr_seen;
    logic              rd_busy, wr_busy;
    logic              rdat_vld_q, dp_oe_q;

    always_ff @(posedge mcb_clk or posedge mcb_rst) begin
        if (mcb_rst) begin
            rd_pipe    <= '0;
            bn_pipe    <= '0;
            wreq_q     <= 1'b0;
            wr_bn      <= '0;
            wr_seen    <= 1'b0;
            rdat_vld_q <= 1'b0;
            dp_oe_q    <= 1'b0;
        end else if (!mcb_sclr_n) begin
            rd_pipe    <= '0;
            bn_pipe    <= '0;
            wreq_q     <= 1'b0;
            wr_bn      <= '0;
            wr_seen    <= 1'b0;
            rdat_vld_q <= 1'b0;
            dp_oe_q    <= 1'b0;
        end else begin
            rd_pipe    <= {rd_pipe[pCL-1:0], rd_cmd};
            bn_pipe    <= {bn_pipe[pCL-1:0], bus.c_bst_num};
            wreq_q     <= bus.c_wdat_req;
            if (bus.c_wdat_req)
                wr_bn <= bus.c_bst_num;
            // Output enable follows the write-data window by one cycle, but
            // only once the write command itself has been seen.
            if (wr_cmd)
                wr_seen <= 1'b1;
            else if (!wr_busy)
                wr_seen <= 1'b0;
            rdat_vld_q <= rd_busy;
            dp_oe_q    <= wr_busy & wr_seen;
        end
    end

    mcb_bst_cnt u_rd_cnt (
        .clk    (mcb_clk),
        .rst    (mcb_rst),
        .sclr_n (mcb_sclr_n),
        .load   (rd_pipe[pCL]),
        .n      (beats(pBL, bn_pipe[pCL])),
        .busy   (rd_busy)
    );

    mcb_bst_cnt u_wr_cnt (
        .clk    (mcb_clk),
        .rst    (mcb_rst),
        .sclr_n (mcb_sclr_n),
        .load   (wreq_q),
        .n      (beats(pBL, wr_bn)),
        .busy   (wr_busy)
    );

    assign bus.d_dp_ie      = rd_busy;
    assign bus.mcb_rdat_vld = rdat_vld_q;
    assign bus.mcb_wdat_req = wr_busy;
    assign bus.d_wr_ld      = wr_busy;
    assign bus.d_dp_oe      = dp_oe_q;
endmodule

// File: tb/tb_mcb_dat_ctrl.sv
// Scoreboard bench for mcb_dat_ctrl: stimulus posts expected per-cycle output
// vectors, a free-running monitor compares every cycle.
module tb_mcb_dat_ctrl;
    logic mcb_clk = 1'b0;
    logic mcb_rst = 1'b1;
    logic mcb_sclr_n = 1'b1;

    mcb_dat_ctrl_if bus ();

    mcb_dat_ctrl #(.pCL(3), .pBL(4)) dut (
        .mcb_clk    (mcb_clk),
        .mcb_rst    (mcb_rst),
        .mcb_sclr_n (mcb_sclr_n),
        .bus        (bus)
    );

    always #5 mcb_clk = ~mcb_clk;

    // Vector bits: 0 rdat_vld, 1 dp_ie, 2 wdat_req, 3 wr_ld, 4 dp_oe
    localparam int MAXC = 1024;
    logic [4:0] exp_v [0:MAXC-1];
    int cyc = 0;
    int checks = 0;
    int fails = 0;

    function automatic logic [4:0] outs();
        return {bus.d_dp_oe, bus.d_wr_ld, bus.mcb_wdat_req, bus.d_dp_ie, bus.mcb_rdat_vld};
    endfunction

    task automatic chk(input string name, input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    always @(posedge mcb_clk) begin
        cyc = cyc + 1;
        #1;
        if (cyc < MAXC) chk("cycle", outs(), exp_v[cyc]);
    end

    task automatic set_win(input int bit_i, input int a, input int b);
        for (int c = a; c <= b; c++) exp_v[c][bit_i] = 1'b1;
    endtask

    task automatic clr_from(input int a);
        for (int c = a; c < MAXC; c++) exp_v[c] = '0;
    endtask

    task automatic exp_read(input int r, input int bn);
        int nb;
        nb = 4 * (bn + 1);
        set_win(1, r + 4, r + 3 + nb);
        set_win(0, r + 5, r + 4 + nb);
    endtask

    task automatic exp_write(input int t, input int bn);
        int nb;
        nb = 4 * (bn + 1);
        set_win(2, t + 1, t + nb);
        set_win(3, t + 1, t + nb);
        set_win(4, t + 2, t + nb + 1);
    endtask

    // Drives one command cycle (sampled at edge cyc+1), then returns inputs to idle.
    task automatic drive(input bit rd, input bit rda, input bit wq, input bit wr,
                         input bit wra, input logic [1:0] bn);
        bus.c_rd = rd; bus.c_rda = rda; bus.c_wdat_req = wq;
        bus.c_wr = wr; bus.c_wra = wra; bus.c_bst_num = bn;
        @(negedge mcb_clk);
        bus.c_rd = 0; bus.c_rda = 0; bus.c_wdat_req = 0;
        bus.c_wr = 0; bus.c_wra = 0; bus.c_bst_num = 2'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge mcb_clk);
    endtask

    initial begin
        int r, t;
        for (int c = 0; c < MAXC; c++) exp_v[c] = '0;
        bus.c_rd = 0; bus.c_rda = 0; bus.c_wdat_req = 0;
        bus.c_wr = 0; bus.c_wra = 0; bus.c_bst_num = 2'd0;
        #8;
        chk("reset_state", outs(), 5'b0);
        idle(2);
        mcb_rst = 1'b0;

        // bn=0 read with auto-precharge straight after reset release
        r = cyc + 1; exp_read(r, 0); drive(0, 1, 0, 0, 0, 2'd0);
        idle(14);
        // bn=1 plain read: 8-beat window
        r = cyc + 1; exp_read(r, 1); drive(1, 0, 0, 0, 0, 2'd1);
        idle(16);
        // bn=0 write with auto-precharge
        t = cyc + 1; exp_write(t, 0);
        drive(0, 0, 1, 0, 0, 2'd0); drive(0, 0, 0, 0, 1, 2'd0);
        idle(12);
        // bn=1 plain write
        t = cyc + 1; exp_write(t, 1);
        drive(0, 0, 1, 0, 0, 2'd1); drive(0, 0, 0, 1, 0, 2'd1);
        idle(16);
        // read and write-data request together; bst_num on the write cycle is ignored
        r = cyc + 1; exp_read(r, 0); exp_write(r, 0);
        drive(1, 0, 1, 0, 0, 2'd0); drive(0, 0, 0, 1, 0, 2'd3);
        idle(14);
        // write requested while an 8-beat read is still in flight
        r = cyc + 1; exp_read(r, 1); exp_write(r + 2, 0);
        drive(1, 0, 0, 0, 0, 2'd1); idle(1);
        drive(0, 0, 1, 0, 0, 2'd0); drive(0, 0, 0, 1, 0, 2'd0);
        idle(16);
        // read restart: bn=1 at R, bn=0 at R+3 -> window ends 4 beats after the second load
        r = cyc + 1;
        set_win(1, r + 4, r + 10); set_win(0, r + 5, r + 11);
        drive(1, 0, 0, 0, 0, 2'd1); idle(2); drive(1, 0, 0, 0, 0, 2'd0);
        idle(16);

        // async reset mid read burst
        r = cyc + 1; exp_read(r, 1);
        drive(1, 0, 0, 0, 0, 2'd1);
        while (cyc < r + 6) @(negedge mcb_clk);
        chk("pre_reset_ie", outs(), 5'b00011);
        #2 mcb_rst = 1'b1;
        #1 chk("async_reset", outs(), 5'b0);
        clr_from(cyc + 1);
        @(negedge mcb_clk);
        mcb_rst = 1'b0;
        idle(14);

        // sync clear mid write burst, overriding a read in the same cycle
        t = cyc + 1; exp_write(t, 1);
        drive(0, 0, 1, 0, 0, 2'd1); drive(0, 0, 0, 1, 0, 2'd1);
        while (cyc < t + 3) @(negedge mcb_clk);
        clr_from(cyc + 1);
        mcb_sclr_n = 1'b0;
        bus.c_rd = 1'b1;
        @(negedge mcb_clk);
        mcb_sclr_n = 1'b1;
        bus.c_rd = 1'b0;
        idle(14);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
